// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: issue/sequencing controller around a combinational alu.
//   Accepts one operation over in_valid/in_ready, captures the operands, runs
//   single-cycle ops through the alu and DIV/REM through a restoring divider,
//   then presents the result over out_valid/out_ready.
// Ports:
//   clk, rst         clock, synchronous active-high reset
//   in_valid/ready   request handshake (in_ready high only in IDLE)
//   in1, in2         32-bit operands rs1, rs2
//   instructions     one-hot op code (bit 0 add .. bit 12 rem)
//   out_valid/ready  result handshake
//   ALUoutput        64-bit result
//   op_err           illegal op code flag, qualified by out_valid
//   busy             high whenever not IDLE

// alu: combinational single-cycle datapath.
//   a, b   operands
//   op     one-hot op code; DIV/REM and anything not one-hot yield 0
//   y      64-bit result (32-bit ops zero-extended)
module alu (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [15:0] op,
  output logic [63:0] y
);
  logic [31:0] r32;

  always_comb begin
    r32 = '0;
    y   = '0;
    case (op)
      16'h0001: r32 = a + b;
      16'h0002: r32 = a - b;
      16'h0004: r32 = a ^ b;
      16'h0008: r32 = a | b;
      16'h0010: r32 = a & b;
      16'h0020: r32 = a << b[4:0];
      16'h0040: r32 = a >> b[4:0];
      16'h0080: r32 = $signed(a) >>> b[4:0];
      16'h0100: r32 = {31'b0, ($signed(a) < $signed(b))};
      16'h0200: r32 = {31'b0, (a < b)};
      default:  r32 = '0;
    endcase
    if (op == 16'h0400) y = {32'b0, a} * {32'b0, b};
    else                y = {32'b0, r32};
  end
endmodule

// state | meaning
// IDLE  | ready for a request
// EXEC  | single-cycle op, DIV/REM corner case or illegal code; result next edge
// DIV   | one setup cycle loading |in1|,|in2|, then 32 restoring iterations
// FIX   | apply quotient/remainder signs and register the result
// DONE  | result presented, waiting for out_ready
module alu_op_sequencer #(
  parameter int XLEN = 32,
  parameter int OPW  = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in1,
  input  logic [XLEN-1:0] in2,
  input  logic [OPW-1:0]  instructions,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [63:0]     ALUoutput,
  output logic            op_err,
  output logic            busy
);
  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_DIV, S_FIX, S_DONE} state_t;

  state_t      state;
  logic [31:0] a_q, b_q;
  logic [15:0] op_q;
  logic        legal_q;
  logic [5:0]  cnt;
  logic [31:0] dq;    // dividend shifting out, quotient shifting in
  logic [31:0] rem;
  logic [31:0] dvs;

  // Legal means exactly one of bits 0..12 set.
  logic legal_in, divrem_in, corner_in;
  assign legal_in  = (instructions != '0) &&
                     ((instructions & (instructions - 16'd1)) == '0) &&
                     (instructions[15:13] == 3'b000);
  assign divrem_in = instructions[11] | instructions[12];
  assign corner_in = (in2 == '0) || (in1 == 32'h8000_0000 && in2 == 32'hFFFF_FFFF);

  // Illegal codes must not execute anything, so the alu sees all zeros.
  logic [31:0] alu_a, alu_b;
  logic [15:0] alu_op;
  logic [63:0] alu_y;
  assign alu_a  = legal_q ? a_q  : '0;
  assign alu_b  = legal_q ? b_q  : '0;
  assign alu_op = legal_q ? op_q : '0;

  alu u_alu (
    .a  (alu_a),
    .b  (alu_b),
    .op (alu_op),
    .y  (alu_y)
  );

  logic [31:0] div_corner, rem_corner;
  assign div_corner = (b_q == '0) ? 32'hFFFF_FFFF : 32'h8000_0000;
  assign rem_corner = (b_q == '0) ? a_q : 32'h0;

  logic [31:0] abs_a, abs_b;
  assign abs_a = a_q[31] ? -a_q : a_q;
  assign abs_b = b_q[31] ? -b_q : b_q;

  // One restoring step: shift next dividend bit into the partial remainder
  // and subtract the divisor; a clear borrow bit means the subtraction fits.
  logic [32:0] shifted, diff;
  assign shifted = {rem, dq[31]};
  assign diff    = shifted - {1'b0, dvs};

  logic [31:0] q_signed, r_signed;
  assign q_signed = (a_q[31] ^ b_q[31]) ? -dq : dq;
  assign r_signed = a_q[31] ? -rem : rem;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      ALUoutput <= '0;
      op_err    <= 1'b0;
      busy      <= 1'b0;
      a_q       <= '0;
      b_q       <= '0;
      op_q      <= '0;
      legal_q   <= 1'b0;
      cnt       <= '0;
      dq        <= '0;
      rem       <= '0;
      dvs       <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (in_valid) begin
            a_q      <= in1;
            b_q      <= in2;
            op_q     <= instructions;
            legal_q  <= legal_in;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            if (legal_in && divrem_in && !corner_in) begin
              state <= S_DIV;
              cnt   <= 6'd33;
            end else begin
              state <= S_EXEC;
            end
          end
        end
        S_EXEC: begin
          state     <= S_DONE;
          out_valid <= 1'b1;
          op_err    <= !legal_q;
          if (!legal_q)     ALUoutput <= '0;
          else if (op_q[11]) ALUoutput <= {32'b0, div_corner};
          else if (op_q[12]) ALUoutput <= {32'b0, rem_corner};
          else               ALUoutput <= alu_y;
        end
        S_DIV: begin
          if (cnt == 6'd33) begin
            rem <= '0;
            dq  <= abs_a;
            dvs <= abs_b;
          end else begin
            rem <= diff[32] ? shifted[31:0] : diff[31:0];
            dq  <= {dq[30:0], ~diff[32]};
          end
          cnt <= cnt - 6'd1;
          if (cnt == 6'd1) state <= S_FIX;
        end
        S_FIX: begin
          state     <= S_DONE;
          out_valid <= 1'b1;
          op_err    <= 1'b0;
          ALUoutput <= {32'b0, (op_q[11] ? q_signed : r_signed)};
        end
        S_DONE: begin
          if (out_ready) begin
            state     <= S_IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            busy      <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          in_ready  <= 1'b1;
          out_valid <= 1'b0;
          busy      <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_alu_op_sequencer.sv
module tb_alu_op_sequencer;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic [15:0] instructions = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] ALUoutput;
  logic        op_err;
  logic        busy;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  alu_op_sequencer dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in1          (in1),
    .in2          (in2),
    .instructions (instructions),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .ALUoutput    (ALUoutput),
    .op_err       (op_err),
    .busy         (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Reference behaviour straight from the op definitions.
  function automatic void model_op(input logic [31:0] a, input logic [31:0] b,
                                   input logic [15:0] op, output logic [63:0] res,
                                   output logic err, output int lat);
    logic [31:0] r32;
    r32 = '0;
    res = '0;
    err = 1'b0;
    lat = 1;
    if ($countones(op) != 1 || op[15:13] != 3'b000) begin
      err = 1'b1;
      return;
    end
    if (op == 16'h0001) r32 = a + b;
    if (op == 16'h0002) r32 = a - b;
    if (op == 16'h0004) r32 = a ^ b;
    if (op == 16'h0008) r32 = a | b;
    if (op == 16'h0010) r32 = a & b;
    if (op == 16'h0020) r32 = a << b[4:0];
    if (op == 16'h0040) r32 = a >> b[4:0];
    if (op == 16'h0080) r32 = $signed(a) >>> b[4:0];
    if (op == 16'h0100) r32 = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
    if (op == 16'h0200) r32 = (a < b) ? 32'd1 : 32'd0;
    if (op == 16'h0800 || op == 16'h1000) begin
      if (b == 32'h0) begin
        r32 = (op == 16'h0800) ? 32'hFFFF_FFFF : a;
      end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
        r32 = (op == 16'h0800) ? 32'h8000_0000 : 32'h0;
      end else begin
        lat = 34;
        if (op == 16'h0800) r32 = $signed(a) / $signed(b);
        else                r32 = $signed(a) % $signed(b);
      end
    end
    if (op == 16'h0400) res = {32'b0, a} * {32'b0, b};
    else                res = {32'b0, r32};
  endfunction

  // Cycle-level scoreboard: at most one op outstanding.
  bit          model_on = 0;
  bit          pending = 0;
  int          valid_at = 0;
  logic [63:0] exp_res = '0;
  logic        exp_err = 1'b0;

  always @(negedge clk) begin
    bit ov;
    int l;
    if (model_on) begin
      ov = pending && (cyc >= valid_at);
      chk("out_valid", {63'b0, out_valid}, {63'b0, ov});
      chk("in_ready", {63'b0, in_ready}, {63'b0, !pending});
      chk("busy", {63'b0, busy}, {63'b0, pending});
      if (ov) begin
        chk("result", ALUoutput, exp_res);
        chk("op_err", {63'b0, op_err}, {63'b0, exp_err});
      end
    end
    if (rst) begin
      pending  = 0;
      model_on = 1;
    end else if (pending && cyc >= valid_at && out_ready) begin
      pending = 0;
    end else if (!pending && in_valid) begin
      model_op(in1, in2, instructions, exp_res, exp_err, l);
      pending  = 1;
      valid_at = cyc + 1 + l;
    end
  end

  // Issue one op, scramble inputs after accept, and check against literals.
  task automatic do_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic [15:0] op, input int stall,
                       input logic [63:0] lit_res, input logic lit_err, input int lit_lat);
    int n;
    int lat;
    in1 = a;
    in2 = b;
    instructions = op;
    in_valid = 1'b1;
    out_ready = (stall == 0);
    n = 0;
    while (!in_ready && n < 100) begin
      @(posedge clk); #2;
      n++;
    end
    chk({nm, "_accept_wait"}, {63'b0, (n < 100)}, 64'd1);
    @(posedge clk); #2;
    in_valid = 1'b0;
    in1 = a ^ 32'h5A5A_A5A5;
    in2 = b + 32'd13;
    instructions = 16'h0400;
    lat = 0;
    do begin
      @(posedge clk); #2;
      lat++;
    end while (!out_valid && lat < 100);
    chk({nm, "_latency"}, 64'(lat), 64'(lit_lat));
    chk({nm, "_value"}, ALUoutput, lit_res);
    chk({nm, "_err"}, {63'b0, op_err}, {63'b0, lit_err});
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #2;
      chk({nm, "_stall_value"}, ALUoutput, lit_res);
      chk({nm, "_stall_in_ready"}, {63'b0, in_ready}, 64'd0);
      chk({nm, "_stall_valid"}, {63'b0, out_valid}, 64'd1);
    end
    out_ready = 1'b1;
    @(posedge clk); #2;
    out_ready = 1'b0;
    chk({nm, "_in_ready_back"}, {63'b0, in_ready}, 64'd1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b0;
    chk("reset_in_ready", {63'b0, in_ready}, 64'd1);
    chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
    chk("reset_result", ALUoutput, 64'd0);
    chk("reset_op_err", {63'b0, op_err}, 64'd0);
    chk("reset_busy", {63'b0, busy}, 64'd0);

    do_op("add",      32'hFFFF_FFFB, 32'd4,         16'h0001, 0, 64'h0000_0000_FFFF_FFFF, 1'b0, 1);
    do_op("slt",      32'hFFFF_FFFB, 32'd3,         16'h0100, 0, 64'd1, 1'b0, 1);
    do_op("sltu",     32'hFFFF_FFFB, 32'd3,         16'h0200, 0, 64'd0, 1'b0, 1);
    do_op("mul",      32'hFFFF_FFFB, 32'd4,         16'h0400, 0, 64'h0000_0003_FFFF_FFEC, 1'b0, 1);
    do_op("sub",      32'd3,         32'd5,         16'h0002, 0, 64'h0000_0000_FFFF_FFFE, 1'b0, 1);
    do_op("sra",      32'h8000_0000, 32'd4,         16'h0080, 0, 64'h0000_0000_F800_0000, 1'b0, 1);
    do_op("srl",      32'h8000_0000, 32'd36,        16'h0040, 0, 64'h0000_0000_0800_0000, 1'b0, 1);
    do_op("sll",      32'd1,         32'd33,        16'h0020, 0, 64'd2, 1'b0, 1);
    do_op("div",      32'hFFFF_FFF9, 32'd2,         16'h0800, 0, 64'h0000_0000_FFFF_FFFD, 1'b0, 34);
    do_op("rem",      32'hFFFF_FFF9, 32'd2,         16'h1000, 0, 64'h0000_0000_FFFF_FFFF, 1'b0, 34);
    do_op("div_neg2", 32'd7,         32'hFFFF_FFFE, 16'h0800, 0, 64'h0000_0000_FFFF_FFFD, 1'b0, 34);
    do_op("rem_neg2", 32'd7,         32'hFFFF_FFFE, 16'h1000, 2, 64'd1, 1'b0, 34);
    do_op("div_by0",  32'd10,        32'd0,         16'h0800, 0, 64'h0000_0000_FFFF_FFFF, 1'b0, 1);
    do_op("rem_by0",  32'd10,        32'd0,         16'h1000, 0, 64'h0000_0000_0000_000A, 1'b0, 1);
    do_op("div_ovf",  32'h8000_0000, 32'hFFFF_FFFF, 16'h0800, 0, 64'h0000_0000_8000_0000, 1'b0, 1);
    do_op("rem_ovf",  32'h8000_0000, 32'hFFFF_FFFF, 16'h1000, 0, 64'd0, 1'b0, 1);
    do_op("xor_stall",32'h1234_5678, 32'h0F0F_0F0F, 16'h0004, 5, 64'h0000_0000_1D3B_5977, 1'b0, 1);
    do_op("div_big",  32'd100,       32'd7,         16'h0800, 3, 64'd14, 1'b0, 34);
    do_op("ill_0003", 32'd9,         32'd9,         16'h0003, 0, 64'd0, 1'b1, 1);
    do_op("ill_0000", 32'd9,         32'd9,         16'h0000, 0, 64'd0, 1'b1, 1);
    do_op("ill_2000", 32'd9,         32'd0,         16'h2000, 0, 64'd0, 1'b1, 1);
    do_op("or_after", 32'h00F0_0000, 32'h0000_000F, 16'h0008, 0, 64'h0000_0000_00F0_000F, 1'b0, 1);

    // Reset in the middle of a divide aborts it.
    in1 = 32'hFFFF_FFF9;
    in2 = 32'd2;
    instructions = 16'h0800;
    in_valid = 1'b1;
    @(posedge clk); #2;
    in_valid = 1'b0;
    repeat (11) begin
      @(posedge clk); #2;
    end
    chk("abort_busy_before", {63'b0, busy}, 64'd1);
    rst = 1'b1;
    @(posedge clk); #2;
    rst = 1'b0;
    chk("abort_out_valid", {63'b0, out_valid}, 64'd0);
    chk("abort_in_ready", {63'b0, in_ready}, 64'd1);
    chk("abort_busy", {63'b0, busy}, 64'd0);
    do_op("and_after", 32'hFF00_FF00, 32'h0FF0_0FF0, 16'h0010, 0, 64'h0000_0000_0F00_0F00, 1'b0, 1);

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
